// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: FSM states, opcode constants and instruction classes shared with the datapath
package multicycle_controller_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALTED
  } state_t;
  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_JUMP, C_HALT, C_ILLEGAL
  } iclass_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOADI = 6'b001110;
  localparam logic [5:0] OP_LOAD  = 6'b001101;
  localparam logic [5:0] OP_STORE = 6'b001100;
  localparam logic [5:0] OP_JUMP  = 6'b000010;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: fetch handshake, data-memory completion, datapath strobes and status
interface multicycle_controller_if;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        dmem_ready;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic        illegal;
  modport master (
    input  start, imem_ready, imem_rdata, dmem_ready,
    output imem_req, imem_addr, instruction, reg_write, mem_read, mem_write,
           pc, busy, halted, illegal
  );
  modport slave (
    output start, imem_ready, imem_rdata, dmem_ready,
    input  imem_req, imem_addr, instruction, reg_write, mem_read, mem_write,
           pc, busy, halted, illegal
  );
endinterface

// File: rtl/multicycle_controller_opcode_decoder.sv
// opcode_decoder: maps a 6-bit opcode to an instruction class; the halt opcode takes priority
module opcode_decoder
  import multicycle_controller_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic [5:0] i_opcode,
  output iclass_t    o_class
);
  always_comb
    o_class = i_opcode == HALT_OPCODE ? C_HALT :
              (i_opcode == OP_RTYPE || i_opcode == OP_LOADI) ? C_ALU :
              i_opcode == OP_LOAD  ? C_LOAD  :
              i_opcode == OP_STORE ? C_STORE :
              i_opcode == OP_JUMP  ? C_JUMP  : C_ILLEGAL;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/mem/writeback sequencer owning PC and IR
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input logic                      clock,
  input logic                      reset,
  multicycle_controller_if.master  bus
);
  state_t      r_state, w_next;
  iclass_t     w_class;
  logic [31:0] r_pc, r_ir;
  logic        r_illegal, r_imem_req, r_reg_write, r_mem_read, r_mem_write, r_busy, r_halted;

  opcode_decoder #(.HALT_OPCODE(HALT_OPCODE)) u_dec (.i_opcode(r_ir[31:26]), .o_class(w_class));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = bus.start ? S_FETCH : S_IDLE;
      S_FETCH:     w_next = bus.imem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    w_next = w_class == C_HALT ? S_HALTED : S_EXECUTE;
      S_EXECUTE:   w_next = w_class == C_ALU ? S_WRITEBACK :
                            (w_class == C_LOAD || w_class == C_STORE) ? S_MEM : S_FETCH;
      S_MEM:       w_next = !bus.dmem_ready ? S_MEM : w_class == C_LOAD ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: w_next = S_FETCH;
      S_HALTED:    w_next = S_HALTED;
      default:     w_next = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they are pure functions of state and IR
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_illegal   <= 1'b0;
      r_imem_req  <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.imem_ready) begin
        r_ir <= bus.imem_rdata;
        r_pc <= r_pc + 32'd4;
      end
      if (r_state == S_EXECUTE && w_class == C_JUMP) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
      r_illegal   <= r_illegal | (r_state == S_EXECUTE && w_class == C_ILLEGAL);
      r_imem_req  <= w_next == S_FETCH;
      r_reg_write <= w_next == S_WRITEBACK;
      r_mem_read  <= w_next == S_MEM && w_class == C_LOAD;
      r_mem_write <= w_next == S_MEM && w_class == C_STORE;
      r_busy      <= !(w_next == S_IDLE || w_next == S_HALTED);
      r_halted    <= w_next == S_HALTED;
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.instruction = r_ir;
  assign bus.reg_write   = r_reg_write;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
  assign bus.illegal     = r_illegal;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_OPCODE, default 6'b111111, meaning the opcode that stops sequencing.
REQ-003 The block SHALL have port clock  input  1  rising-edge clock, the single clock of the block.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  begin sequencing from IDLE.
REQ-006 The block SHALL have ports imem_req  output  1, imem_addr  output  32 and imem_ready  input  1, forming the instruction-fetch handshake.
REQ-007 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 The block SHALL have port instruction  output  32  held IR, driven to the datapath instruction port.
REQ-009 The block SHALL have ports reg_write, mem_read and mem_write  output  1 each, as datapath strobes.
REQ-010 The block SHALL have port dmem_ready  input  1  data-memory completion for LOAD/STORE.
REQ-011 The block SHALL have ports pc  output  32, busy  output  1, halted  output  1 and illegal  output  1 (sticky).

Function
REQ-012 The FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK and HALTED.
REQ-013 IDLE -> FETCH SHALL occur on start=1; otherwise the FSM SHALL remain in IDLE.
REQ-014 In FETCH, imem_req=1 and imem_addr=pc, held stable until imem_ready=1; at that edge IR<=imem_rdata, pc<=pc+4 (mod 2^32, wraps), -> DECODE.
REQ-015 Opcode SHALL be IR[31:26]; DECODE SHALL always take one cycle and -> EXECUTE, except HALT_OPCODE -> HALTED.
REQ-016 R-type (000000) and LOADI (001110) SHALL follow EXECUTE -> WRITEBACK.
REQ-017 LOAD (001101) SHALL follow EXECUTE -> MEM -> WRITEBACK; STORE (001100) SHALL follow EXECUTE -> MEM -> FETCH.
REQ-018 JUMP (000010) SHALL set, in EXECUTE, pc<={pc[31:28], IR[25:0], 2'b00} and -> FETCH.
REQ-019 Any other opcode SHALL set illegal=1, behave as NOP and go EXECUTE -> FETCH.
REQ-020 MEM SHALL assert mem_read (LOAD) or mem_write (STORE) every cycle until dmem_ready=1, then leave MEM on that edge.
REQ-021 WRITEBACK SHALL assert reg_write for exactly one cycle, then -> FETCH.
REQ-022 Strobes SHALL be Moore outputs decoded from state and IR only; at most one of reg_write/mem_read/mem_write SHALL be high in any cycle.
REQ-023 busy SHALL be 1 in every state except IDLE and HALTED; halted SHALL be 1 only in HALTED.
REQ-024 HALTED SHALL be left only by reset; start SHALL be ignored there and during busy.
REQ-025 Per-instruction latency with zero-wait memories SHALL be: R-type/LOADI 4, LOAD 5, STORE 4, JUMP/illegal 3 cycles.
REQ-026 instruction SHALL change only on the FETCH-completion edge.

Reset
REQ-027 Asserting reset SHALL, at any time including mid-handshake, force state=IDLE, pc=RESET_PC, IR=0, illegal=0 and all strobes, imem_req, busy and halted to 0.
REQ-028 The first FETCH after reset release SHALL require a new start pulse.

Structure
REQ-029 State encoding and opcode constants (RTYPE, LOADI, LOAD, STORE, JUMP) SHALL live in the shared instructions include, used by both the datapath and this block.
REQ-030 One sub-module, opcode_decoder, SHALL be instantiated to map IR[31:26] to an instruction class; the FSM, PC and IR SHALL reside in multicycle_controller.

Verification
REQ-031 Reset, start, imem_rdata=32'b001110_00001_...; zero-wait -> imem_addr=0, reg_write high in cycle 4, pc=4, back to FETCH.
REQ-032 LOAD 32'b001101_00001_00000_0...; dmem_ready delayed 3 cycles -> mem_read high for 4 cycles, then one reg_write pulse.
REQ-033 imem_ready held low 5 cycles -> imem_req and imem_addr stable throughout, IR unchanged until ready.
REQ-034 JUMP with IR[25:0]=26'h3 at pc=0 -> next imem_addr=32'h0000_000C; illegal opcode 6'b010101 -> illegal=1, pc advances by 4.
REQ-035 HALT_OPCODE fetched -> halted=1, busy=0, start ignored; reset asserted mid-MEM -> all outputs at reset values within the same cycle.
